// File: rtl/memory_responder.sv
// memory_responder: unified instruction/data memory behind the multi-cycle
// MIPS address interface. One request at a time, WAIT_STATES wait cycles,
// then a one-cycle MEM_READY strobe with an error flag.
//
// Handshake: a request (MEM_RD or MEM_WR high) is sampled only in IDLE; the
// requester holds it stable until MEM_READY, which is high for exactly one
// cycle; ADDR_ERR is meaningful only while MEM_READY is high.
module memory_responder #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH_WORDS   = 1024,
  parameter int WAIT_STATES   = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     MEM_RD,
  input  logic                     MEM_WR,
  input  logic [ADDRESS_WIDTH-1:0] Addr,
  input  logic [DATA_WIDTH-1:0]    WR_DATA,
  input  logic [1:0]               SIZE,
  input  logic                     UNSIGNED,
  output logic [DATA_WIDTH-1:0]    RAM_OUT,
  output logic                     MEM_READY,
  output logic                     MEM_BUSY,
  output logic                     ADDR_ERR,
  output logic [1:0]               state_dbg
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_RESPOND = 2'd2
  } state_t;

  state_t state, state_next;
  logic [3:0] cnt, cnt_next;

  // Request fields captured at acceptance
  logic                     rd_q, wr_q, uns_q, err_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [1:0]               size_q;

  // Effective request: live inputs in IDLE (needed when WAIT_STATES is 0 and
  // the accepting edge is also the commit edge), latched copy otherwise.
  logic                     rd_eff, wr_eff, uns_eff, err_eff;
  logic [ADDRESS_WIDTH-1:0] addr_eff;
  logic [DATA_WIDTH-1:0]    wdata_eff;
  logic [1:0]               size_eff;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] rd_word, rd_shift, rd_ext, wword;
  logic [15:0]           rd_half;
  logic [3:0]            be;
  logic                  req, enter_respond, commit;

  assign req       = MEM_RD | MEM_WR;
  assign state_dbg = state;

  // Select live or latched request fields
  always_comb begin
    if (state == S_IDLE) begin
      rd_eff    = MEM_RD;
      wr_eff    = MEM_WR;
      uns_eff   = UNSIGNED;
      addr_eff  = Addr;
      wdata_eff = WR_DATA;
      size_eff  = SIZE;
    end else begin
      rd_eff    = rd_q;
      wr_eff    = wr_q;
      uns_eff   = uns_q;
      addr_eff  = addr_q;
      wdata_eff = wdata_q;
      size_eff  = size_q;
    end
  end

  // Error classification: malformed op, reserved size, misalignment, range
  always_comb begin
    err_eff = 1'b0;
    if (rd_eff && wr_eff)                              err_eff = 1'b1;
    if (size_eff == 2'b11)                             err_eff = 1'b1;
    if (size_eff == 2'b01 && addr_eff[0])              err_eff = 1'b1;
    if (size_eff == 2'b10 && addr_eff[1:0] != 2'b00)   err_eff = 1'b1;
    if (|addr_eff[ADDRESS_WIDTH-1:IDX_W+2])            err_eff = 1'b1;
  end

  // Little-endian lane extraction and extension for reads
  always_comb begin
    idx      = addr_eff[IDX_W+1:2];
    rd_word  = mem[idx];
    rd_shift = rd_word >> {addr_eff[1:0], 3'b000};
    rd_half  = addr_eff[1] ? rd_word[31:16] : rd_word[15:0];
    case (size_eff)
      2'b00:   rd_ext = uns_eff ? {24'h0, rd_shift[7:0]} : {{24{rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   rd_ext = uns_eff ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: rd_ext = rd_word;
    endcase
  end

  // Byte-lane enables and replicated write data
  always_comb begin
    case (size_eff)
      2'b00: begin
        be    = 4'b0001 << addr_eff[1:0];
        wword = {4{wdata_eff[7:0]}};
      end
      2'b01: begin
        be    = addr_eff[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata_eff[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wword = wdata_eff;
      end
    endcase
  end

  // Next-state, counter and strobe outputs
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    MEM_READY  = 1'b0;
    ADDR_ERR   = 1'b0;
    MEM_BUSY   = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (req) begin
          cnt_next   = 4'(WAIT_STATES);
          state_next = (WAIT_STATES == 0) ? S_RESPOND : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_next = cnt - 4'd1;
        if (cnt <= 4'd1) state_next = S_RESPOND;
      end
      S_RESPOND: begin
        MEM_READY  = 1'b1;
        ADDR_ERR   = err_q;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign enter_respond = (state_next == S_RESPOND) && (state != S_RESPOND);
  assign commit        = enter_respond && !err_eff && !RST;

  // State and wait counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Capture the request at acceptance
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= 2'b00;
    end else if (state == S_IDLE && req) begin
      rd_q    <= MEM_RD;
      wr_q    <= MEM_WR;
      uns_q   <= UNSIGNED;
      err_q   <= err_eff;
      addr_q  <= Addr;
      wdata_q <= WR_DATA;
      size_q  <= SIZE;
    end
  end

  // Read data register, updated only by a successful read
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RAM_OUT <= '0;
    end else if (commit && rd_eff) begin
      RAM_OUT <= rd_ext;
    end
  end

  // Storage write; contents deliberately not reset
  always_ff @(posedge CLK) begin
    if (commit && wr_eff) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem[idx][8*k +: 8] <= wword[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: one instance with two wait states and
// one with none, sharing clock and reset.
module tb_memory_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance with WAIT_STATES = 2
  logic        rd2, wr2, uns2;
  logic [31:0] addr2, wd2;
  logic [1:0]  sz2;
  logic [31:0] out2;
  logic        rdy2, busy2, err2;
  logic [1:0]  st2;

  // Instance with WAIT_STATES = 0
  logic        rd0, wr0, uns0;
  logic [31:0] addr0, wd0;
  logic [1:0]  sz0;
  logic [31:0] out0;
  logic        rdy0, busy0, err0;
  logic [1:0]  st0;

  memory_responder #(.WAIT_STATES(2)) dut (
    .CLK(clk), .RST(rst), .MEM_RD(rd2), .MEM_WR(wr2), .Addr(addr2),
    .WR_DATA(wd2), .SIZE(sz2), .UNSIGNED(uns2), .RAM_OUT(out2),
    .MEM_READY(rdy2), .MEM_BUSY(busy2), .ADDR_ERR(err2), .state_dbg(st2)
  );

  memory_responder #(.WAIT_STATES(0)) dut_z (
    .CLK(clk), .RST(rst), .MEM_RD(rd0), .MEM_WR(wr0), .Addr(addr0),
    .WR_DATA(wd0), .SIZE(sz0), .UNSIGNED(uns0), .RAM_OUT(out0),
    .MEM_READY(rdy0), .MEM_BUSY(busy0), .ADDR_ERR(err0), .state_dbg(st0)
  );

  // sel = 0 targets dut, sel = 1 targets dut_z
  logic        sel = 1'b0;
  logic [31:0] o_out;
  logic        o_rdy, o_busy, o_err;
  logic [1:0]  o_st;
  always_comb begin
    o_out  = sel ? out0  : out2;
    o_rdy  = sel ? rdy0  : rdy2;
    o_busy = sel ? busy0 : busy2;
    o_err  = sel ? err0  : err2;
    o_st   = sel ? st0   : st2;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total  = 0;
  int passed = 0;
  logic [32:0] exp_q[$];
  logic [31:0] hold [2];
  int rdy_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [1:0] sz, input logic uns);
    if (sel) begin
      rd0 = rd; wr0 = wr; addr0 = a; wd0 = wd; sz0 = sz; uns0 = uns;
    end else begin
      rd2 = rd; wr2 = wr; addr2 = a; wd2 = wd; sz2 = sz; uns2 = uns;
    end
  endtask

  // One complete access; exp_data is the read result for good reads and is
  // ignored otherwise (RAM_OUT must keep the last good read value).
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [1:0] sz, input logic uns,
                        input logic exp_err, input logic [31:0] exp_data,
                        input bit disturb, input string tag);
    logic [32:0] e;
    int lat;
    bit got;
    @(negedge clk);
    drive(rd, wr, a, wd, sz, uns);
    if (rd && !wr && !exp_err) hold[sel] = exp_data;
    exp_q.push_back({exp_err, hold[sel]});
    lat = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) check({tag, " busy"}, 32'(o_busy), 32'd1);
      if (o_rdy) got = 1;
      else if (disturb) drive(rd, wr, $urandom, $urandom, 2'($urandom_range(0, 3)), uns);
    end
    check({tag, " ready"}, 32'(got), 32'd1);
    e = exp_q.pop_front();
    if (got) begin
      rdy_cyc = cyc;
      check({tag, " latency"}, 32'(lat), sel ? 32'd1 : 32'd3);
      check({tag, " err"}, 32'(o_err), 32'(e[32]));
      check({tag, " data"}, o_out, e[31:0]);
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    @(posedge clk); #1;
    check({tag, " ready drop"}, 32'(o_rdy), 32'd0);
    check({tag, " err drop"}, 32'(o_err), 32'd0);
    check({tag, " idle"}, 32'(o_busy), 32'd0);
  endtask

  initial begin
    int c1, c2;
    bit saw;
    hold[0] = 32'h0;
    hold[1] = 32'h0;
    rst = 1'b1;
    sel = 1'b1; drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    sel = 1'b0; drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #0;
      check("rst ram_out", o_out, 32'h0);
      check("rst ready", 32'(o_rdy), 32'd0);
      check("rst busy", 32'(o_busy), 32'd0);
      check("rst err", 32'(o_err), 32'd0);
      check("rst state", 32'(o_st), 32'd0);
    end
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Word write then read
    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 1'b0, 32'h0, 1'b0, "wr 0x10");
    access(1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, "rd 0x10");

    // Sub-word access
    access(1'b0, 1'b1, 32'h20, 32'h11223344, 2'b10, 1'b0, 1'b0, 32'h0, 1'b0, "wr 0x20");
    access(1'b0, 1'b1, 32'h22, 32'h00000080, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, "wrb 0x22");
    access(1'b1, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 1'b0, 32'h11803344, 1'b0, "rd 0x20");
    access(1'b1, 1'b0, 32'h22, 32'h0, 2'b00, 1'b0, 1'b0, 32'hFFFFFF80, 1'b0, "rdb s 0x22");
    access(1'b1, 1'b0, 32'h22, 32'h0, 2'b00, 1'b1, 1'b0, 32'h00000080, 1'b0, "rdb u 0x22");
    access(1'b1, 1'b0, 32'h22, 32'h0, 2'b01, 1'b0, 1'b0, 32'h00001180, 1'b0, "rdh s 0x22");
    access(1'b0, 1'b1, 32'h20, 32'h0000BEEF, 2'b01, 1'b0, 1'b0, 32'h0, 1'b0, "wrh 0x20");
    access(1'b1, 1'b0, 32'h20, 32'h0, 2'b01, 1'b0, 1'b0, 32'hFFFFBEEF, 1'b0, "rdh s 0x20");
    access(1'b1, 1'b0, 32'h23, 32'h0, 2'b00, 1'b1, 1'b0, 32'h00000011, 1'b0, "rdb u 0x23");

    // Errors; RAM_OUT must keep 0x00000011
    access(1'b1, 1'b0, 32'h22, 32'h0, 2'b10, 1'b0, 1'b1, 32'h0, 1'b0, "err word mis");
    access(1'b1, 1'b0, 32'h21, 32'h0, 2'b01, 1'b0, 1'b1, 32'h0, 1'b0, "err half mis");
    access(1'b1, 1'b1, 32'h10, 32'h0, 2'b10, 1'b0, 1'b1, 32'h0, 1'b0, "err rd+wr");
    access(1'b1, 1'b0, 32'h10, 32'h0, 2'b11, 1'b0, 1'b1, 32'h0, 1'b0, "err size11");
    access(1'b0, 1'b1, 32'h0, 32'h55AA55AA, 2'b10, 1'b0, 1'b0, 32'h0, 1'b0, "wr 0x0");
    access(1'b0, 1'b1, 32'h1000, 32'hFFFFFFFF, 2'b10, 1'b0, 1'b1, 32'h0, 1'b0, "err range");
    access(1'b1, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0, 1'b0, 32'h55AA55AA, 1'b0, "rd 0x0");

    // Reset in the middle of WAIT drops the write
    access(1'b0, 1'b1, 32'h30, 32'h12345678, 2'b10, 1'b0, 1'b0, 32'h0, 1'b0, "wr 0x30");
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h30, 32'hCAFEF00D, 2'b10, 1'b0);
    @(posedge clk); #1;
    check("mid busy", 32'(o_busy), 32'd1);
    #2;
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    #1;
    check("mid rst ram_out", o_out, 32'h0);
    check("mid rst ready", 32'(o_rdy), 32'd0);
    check("mid rst busy", 32'(o_busy), 32'd0);
    check("mid rst err", 32'(o_err), 32'd0);
    check("mid rst state", 32'(o_st), 32'd0);
    hold[0] = 32'h0;
    hold[1] = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    saw = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (o_rdy) saw = 1;
    end
    check("mid no ready", 32'(saw), 32'd0);
    access(1'b1, 1'b0, 32'h30, 32'h0, 2'b10, 1'b0, 1'b0, 32'h12345678, 1'b0, "rd 0x30");

    // Inputs changed during WAIT are ignored
    access(1'b0, 1'b1, 32'h44, 32'h0BADF00D, 2'b10, 1'b0, 1'b0, 32'h0, 1'b0, "wr 0x44");
    access(1'b0, 1'b1, 32'h40, 32'hA5A55A5A, 2'b10, 1'b0, 1'b0, 32'h0, 1'b1, "wr disturbed");
    access(1'b1, 1'b0, 32'h40, 32'h0, 2'b10, 1'b0, 1'b0, 32'hA5A55A5A, 1'b0, "rd 0x40");
    access(1'b1, 1'b0, 32'h44, 32'h0, 2'b10, 1'b0, 1'b0, 32'h0BADF00D, 1'b0, "rd 0x44");

    // Zero wait states, back-to-back reads
    sel = 1'b1;
    access(1'b0, 1'b1, 32'h8, 32'h00C0FFEE, 2'b10, 1'b0, 1'b0, 32'h0, 1'b0, "z wr 0x8");
    access(1'b1, 1'b0, 32'h8, 32'h0, 2'b10, 1'b0, 1'b0, 32'h00C0FFEE, 1'b0, "z rd1");
    c1 = rdy_cyc;
    access(1'b1, 1'b0, 32'h8, 32'h0, 2'b00, 1'b1, 1'b0, 32'h000000EE, 1'b0, "z rd2");
    c2 = rdy_cyc;
    check("z spacing", 32'(c2 - c1), 32'd2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
